// File: rtl/data_mem_dump_ctrl.sv
// rtl/data_mem_dump_ctrl.sv - debug dump sequencer: halts pipeline, reads data memory, streams bytes
//
// Purpose: on i_dump_start, request a pipeline halt, then read every word of
// the data memory via the debug port and stream it out byte by byte
// (little-endian) on a valid/ready interface feeding the UART TX path.
//
// Optional feature macro: DUMP_CHECKSUM_EN. When defined, an 8-bit XOR of all
// streamed bytes is appended as one extra byte after the last data byte.
//
// Ports:
//   i_clk, i_rst_n         clock, synchronous active-low reset
//   i_dump_start, i_abort  dump request / cancel
//   o_halt_req, i_pipe_halted  pipeline halt handshake
//   o_d_en, o_d_addr, i_d_r_data  memory debug read port (data one cycle after o_d_en)
//   o_tx_data, o_tx_valid, i_tx_ready  byte stream
//   o_busy, o_done         status: busy outside IDLE, one-cycle completion pulse

module data_mem_dump_ctrl #(
    parameter int NB_DATA_BUS      = 32,
    parameter int NB_BYTE          = 8,
    parameter int N_ADDRESS        = 128,
    parameter int N_ADDRESS_WORDS  = N_ADDRESS / 4,
    parameter int NB_ADDRESS_WORDS = $clog2(N_ADDRESS_WORDS)
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_dump_start,
    input  logic                        i_abort,
    output logic                        o_halt_req,
    input  logic                        i_pipe_halted,
    output logic                        o_d_en,
    output logic [NB_ADDRESS_WORDS-1:0] o_d_addr,
    input  logic [NB_DATA_BUS-1:0]      i_d_r_data,
    output logic [NB_BYTE-1:0]          o_tx_data,
    output logic                        o_tx_valid,
    input  logic                        i_tx_ready,
    output logic                        o_busy,
    output logic                        o_done
);

    localparam logic [NB_ADDRESS_WORDS-1:0] LAST_WORD = NB_ADDRESS_WORDS'(N_ADDRESS_WORDS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_HALT,
        ST_READ,
        ST_LATCH,
        ST_SEND,
`ifdef DUMP_CHECKSUM_EN
        ST_CKSUM,
`endif
        ST_DONE
    } state_e;

    state_e                      state_q, state_d;
    logic [NB_ADDRESS_WORDS-1:0] word_cnt_q, word_cnt_d;
    logic [1:0]                  byte_cnt_q, byte_cnt_d;
    logic [NB_DATA_BUS-1:0]      shift_q, shift_d;
`ifdef DUMP_CHECKSUM_EN
    logic [NB_BYTE-1:0]          cksum_q, cksum_d;
`endif
    logic [NB_BYTE-1:0]          tx_data_d;

    always_comb begin
        state_d    = state_q;
        word_cnt_d = word_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
`ifdef DUMP_CHECKSUM_EN
        cksum_d    = cksum_q;
`endif
        case (state_q)
            ST_IDLE: begin
                word_cnt_d = '0;
                if (i_dump_start) begin
                    state_d = i_pipe_halted ? ST_READ : ST_WAIT_HALT;
`ifdef DUMP_CHECKSUM_EN
                    cksum_d = '0;
`endif
                end
            end
            ST_WAIT_HALT: begin
                if (i_pipe_halted) state_d = ST_READ;
            end
            ST_READ: state_d = ST_LATCH;
            ST_LATCH: begin
                shift_d    = i_d_r_data;
                byte_cnt_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (i_tx_ready) begin
`ifdef DUMP_CHECKSUM_EN
                    cksum_d = cksum_q ^ shift_q[NB_BYTE-1:0];
`endif
                    if (byte_cnt_q != 2'd3) begin
                        shift_d    = shift_q >> NB_BYTE;
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end else if (word_cnt_q != LAST_WORD) begin
                        word_cnt_d = word_cnt_q + 1'b1;
                        state_d    = ST_READ;
                    end else begin
`ifdef DUMP_CHECKSUM_EN
                        state_d = ST_CKSUM;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef DUMP_CHECKSUM_EN
            ST_CKSUM: begin
                if (i_tx_ready) state_d = ST_DONE;
            end
`endif
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        // Abort wins over any same-cycle handshake; nothing else needs undoing
        // because every counter is re-initialised on the next start.
        if (i_abort && state_q != ST_IDLE) state_d = ST_IDLE;

        // Byte presented in the next cycle; held stable across backpressure
        // because shift_d only moves on an accepted handshake.
        tx_data_d = '0;
        if (state_d == ST_SEND) tx_data_d = shift_d[NB_BYTE-1:0];
`ifdef DUMP_CHECKSUM_EN
        if (state_d == ST_CKSUM) tx_data_d = cksum_d;
`endif
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
`ifdef DUMP_CHECKSUM_EN
            cksum_q    <= '0;
`endif
            o_halt_req <= 1'b0;
            o_d_en     <= 1'b0;
            o_d_addr   <= '0;
            o_tx_data  <= '0;
            o_tx_valid <= 1'b0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            state_q    <= state_d;
            word_cnt_q <= word_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
`ifdef DUMP_CHECKSUM_EN
            cksum_q    <= cksum_d;
`endif
            // Outputs are registered from the next state so they line up with state_q.
            o_halt_req <= (state_d != ST_IDLE);
            o_busy     <= (state_d != ST_IDLE);
            o_d_en     <= (state_d == ST_READ);
            o_d_addr   <= (state_d == ST_READ) ? word_cnt_d : '0;
`ifdef DUMP_CHECKSUM_EN
            o_tx_valid <= (state_d == ST_SEND) || (state_d == ST_CKSUM);
`else
            o_tx_valid <= (state_d == ST_SEND);
`endif
            o_tx_data  <= tx_data_d;
            o_done     <= (state_d == ST_DONE);
        end
    end

endmodule

// File: tb/tb_data_mem_dump_ctrl.sv
// tb/tb_data_mem_dump_ctrl.sv - self-checking bench for data_mem_dump_ctrl

module tb_data_mem_dump_ctrl;

    localparam int N_WORDS = 32;
`ifdef DUMP_CHECKSUM_EN
    localparam int EXP_BYTES = 4 * N_WORDS + 1;
    localparam int EXP_DONE  = 194;
`else
    localparam int EXP_BYTES = 4 * N_WORDS;
    localparam int EXP_DONE  = 193;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        dump_start = 1'b0;
    logic        abort = 1'b0;
    logic        halt_req;
    logic        pipe_halted = 1'b1;
    logic        d_en;
    logic [4:0]  d_addr;
    logic [31:0] d_r_data = '0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        busy;
    logic        done;

    data_mem_dump_ctrl dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_dump_start(dump_start), .i_abort(abort),
        .o_halt_req(halt_req), .i_pipe_halted(pipe_halted),
        .o_d_en(d_en), .o_d_addr(d_addr), .i_d_r_data(d_r_data),
        .o_tx_data(tx_data), .o_tx_valid(tx_valid), .i_tx_ready(tx_ready),
        .o_busy(busy), .o_done(done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory: registered debug read, data valid one cycle after o_d_en.
    logic [31:0] mem [N_WORDS];
    always @(posedge clk) if (d_en) d_r_data <= mem[d_addr];

    // Model state: expected byte stream and progress through it.
    logic [7:0] exp_q [$];
    logic [7:0] rx_q [$];
    int idx = 0, rd_idx = 0;
    int first_den = -1, first_valid = -1, done_cyc = -1, done_cnt = 0;
    bit done_seen = 1'b0;
    int t0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    task automatic build_exp();
        logic [7:0] x;
        x = 8'h00;
        exp_q.delete();
        for (int w = 0; w < N_WORDS; w++)
            for (int b = 0; b < 4; b++) begin
                exp_q.push_back(mem[w][8*b +: 8]);
                x = x ^ mem[w][8*b +: 8];
            end
`ifdef DUMP_CHECKSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic fill_random();
        for (int w = 0; w < N_WORDS; w++) mem[w] = $urandom;
    endtask

    // Per-cycle compare against the model while out of reset.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("halt_eq_busy", 32'(halt_req), 32'(busy));
            if (!busy) chk("idle_quiet", {29'd0, d_en, tx_valid, done}, 32'd0);
            if (d_en) begin
                chk("d_addr", 32'(d_addr), 32'(rd_idx));
                chk("read_after_word_sent", 32'(idx), 32'(rd_idx * 4));
                chk("den_excl_valid", 32'(tx_valid), 32'd0);
                if (first_den < 0) first_den = cyc;
                rd_idx++;
            end
            if (tx_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (idx < exp_q.size()) chk("tx_data", 32'(tx_data), 32'(exp_q[idx]));
                else chk("tx_overrun", 32'(idx), 32'(exp_q.size()));
                if (tx_ready && !abort) begin
                    rx_q.push_back(tx_data);
                    idx++;
                end
            end
            if (done) begin
                chk("done_bytes", 32'(idx), 32'(exp_q.size()));
                chk("done_reads", 32'(rd_idx), 32'(N_WORDS));
                done_seen = 1'b1;
                done_cyc  = cyc;
                done_cnt++;
            end
        end
    end

    task automatic start_dump();
        @(posedge clk); #1;
        idx = 0; rd_idx = 0; rx_q.delete();
        first_den = -1; first_valid = -1; done_cyc = -1; done_seen = 1'b0;
        dump_start = 1'b1;
        t0 = cyc;
        @(posedge clk); #1;
        dump_start = 1'b0;
    endtask

    task automatic wait_done(input bit rnd_ready);
        int n;
        n = 0;
        while (!done_seen && n < 3000) begin
            if (rnd_ready) tx_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
            n++;
        end
        chk("done_timeout", 32'(done_seen), 32'd1);
        tx_ready = 1'b1;
        @(negedge clk);
        chk("halt_drop_after_done", 32'(halt_req), 32'd0);
        chk("busy_drop_after_done", 32'(busy), 32'd0);
        chk("rx_len", 32'(rx_q.size()), 32'(EXP_BYTES));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int rise, dcnt, n;

        // Reset held with dump_start asserted: everything stays quiet.
        rst_n = 1'b0; dump_start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); @(negedge clk);
            chk("rst_outputs", {13'd0, halt_req, d_en, d_addr, tx_data, tx_valid, busy, done}, 32'd0);
        end
        @(posedge clk); #1;
        dump_start = 1'b0; rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Full dump, halted, always ready: latency and byte order.
        fill_random();
        mem[0] = 32'hDEADBEEF; mem[N_WORDS-1] = 32'h01020304;
        build_exp();
        chk("model_len", 32'(exp_q.size()), 32'(EXP_BYTES));
        chk("model_b0", 32'(exp_q[0]), 32'hEF);
        chk("model_b127", 32'(exp_q[127]), 32'h01);
        pipe_halted = 1'b1; tx_ready = 1'b1;
        start_dump();
        wait_done(1'b0);
        chk("lat_den", 32'(first_den - t0), 32'd1);
        chk("lat_valid", 32'(first_valid - t0), 32'd3);
        chk("lat_done", 32'(done_cyc - t0), 32'(EXP_DONE));
        chk("rx0", 32'(rx_q[0]), 32'hEF);
        chk("rx1", 32'(rx_q[1]), 32'hBE);
        chk("rx2", 32'(rx_q[2]), 32'hAD);
        chk("rx3", 32'(rx_q[3]), 32'hDE);
        chk("rx124", 32'(rx_q[124]), 32'h04);
        chk("rx125", 32'(rx_q[125]), 32'h03);
        chk("rx126", 32'(rx_q[126]), 32'h02);
        chk("rx127", 32'(rx_q[127]), 32'h01);

        // Backpressure on the second byte of word 0, then random ready.
        fill_random();
        mem[0] = 32'hDEADBEEF;
        build_exp();
        start_dump();
        n = 0;
        while (!(tx_valid && idx == 1) && n < 50) begin
            @(posedge clk); #1; n++;
        end
        chk("bp_reach", 32'(idx), 32'd1);
        tx_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_data", 32'(tx_data), 32'hBE);
            chk("bp_hold_valid", 32'(tx_valid), 32'd1);
            @(posedge clk); #1;
        end
        wait_done(1'b1);
        chk("bp_rx1", 32'(rx_q[1]), 32'hBE);

        // Halt handshake: pipeline halts 10 cycles after the request.
        fill_random();
        build_exp();
        pipe_halted = 1'b0;
        start_dump();
        @(negedge clk);
        chk("halt_req_c1", 32'(halt_req), 32'd1);
        chk("no_den_waiting", 32'(d_en), 32'd0);
        while (cyc < t0 + 10) begin
            @(posedge clk); #1;
        end
        pipe_halted = 1'b1;
        rise = cyc;
        wait_done(1'b0);
        chk("halt_to_den", 32'(first_den - rise), 32'd1);

        // Abort on word 5 byte 2 with a same-cycle handshake; then restart.
        fill_random();
        build_exp();
        start_dump();
        n = 0;
        while (!(tx_valid && idx == 22) && n < 2000) begin
            tx_ready = $urandom_range(0, 1) != 0;
            @(posedge clk); #1; n++;
        end
        chk("abort_reach", 32'(idx), 32'd22);
        dcnt = done_cnt;
        abort = 1'b1; tx_ready = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        chk("abort_valid", 32'(tx_valid), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_halt", 32'(halt_req), 32'd0);
        chk("abort_rx_len", 32'(rx_q.size()), 32'd22);
        repeat (5) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt), 32'(dcnt));
        start_dump();
        wait_done(1'b1);

        // Reset in the middle of a dump: no completion pulse.
        fill_random();
        build_exp();
        start_dump();
        repeat (40) @(posedge clk);
        #1;
        dcnt = done_cnt;
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("midrst_outputs", {13'd0, halt_req, d_en, d_addr, tx_data, tx_valid, busy, done}, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("midrst_no_done", 32'(done_cnt), 32'(dcnt));

        // Random dumps with random backpressure.
        for (int r = 0; r < 2; r++) begin
            fill_random();
            build_exp();
            start_dump();
            wait_done(1'b1);
        end

`ifdef DUMP_CHECKSUM_EN
        for (int w = 0; w < N_WORDS; w++) mem[w] = 32'd0;
        mem[0] = 32'h000000FF;
        build_exp();
        chk("ck_model_last", 32'(exp_q[128]), 32'hFF);
        start_dump();
        wait_done(1'b1);
        chk("ck_len", 32'(rx_q.size()), 32'd129);
        chk("ck_last", 32'(rx_q[128]), 32'hFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
